// File: rtl/axis_mon_pkg.sv
// Shared types and helpers for the AXI-Stream frame monitor.
// Holds the monitor state enum, the tuser error-bit position and a saturating increment.
package axis_mon_pkg;

    typedef enum logic {
        PASS,
        DROP
    } mon_state_t;

    localparam int USER_ERR_BIT = 0;

    // Increments a counter of up to 64 bits, holding at all-ones for the given width.
    function automatic logic [63:0] sat_inc(input logic [63:0] value, input int width);
        logic [63:0] top;
        top = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        return (value >= top) ? top : value + 64'd1;
    endfunction

endpackage

// File: rtl/axis_skid_reg.sv
// Full-throughput two-entry (main + temp) register slice with a registered upstream ready.
// Carries an opaque payload vector; the upstream ready falls only while the temp entry is occupied.
module axis_skid_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready
);

    logic [WIDTH-1:0] temp_data;
    logic             temp_valid;
    logic             ready_early;

    // Ready is predicted one cycle ahead so the temp entry can absorb the beat already in flight.
    assign ready_early = m_ready || (!temp_valid && (!m_valid || !s_valid));

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid    <= 1'b0;
            s_ready    <= 1'b0;
            temp_valid <= 1'b0;
            m_data     <= '0;
            temp_data  <= '0;
        end else begin
            s_ready <= ready_early;
            if (s_ready) begin
                if (m_ready || !m_valid) begin
                    m_valid <= s_valid;
                    m_data  <= s_data;
                end else begin
                    temp_valid <= s_valid;
                    temp_data  <= s_data;
                end
            end else if (m_ready) begin
                m_valid    <= temp_valid;
                m_data     <= temp_data;
                temp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/axis_frame_monitor.sv
// AXI-Stream frame monitor: truncates frames longer than MAX_LEN and keeps per-tid statistics.
// Statistics counters exist only when AXIS_FRAME_MONITOR_STATS_EN is defined; otherwise stat_* read 0.
module axis_frame_monitor
    import axis_mon_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH  = (DATA_WIDTH / 8),
    parameter int ID_WIDTH    = 8,
    parameter int DEST_WIDTH  = 1,
    parameter int USER_WIDTH  = 1,
    parameter int S_COUNT     = 4,
    parameter int MAX_LEN     = 256,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_WIDTH-1:0]        s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]        s_axis_tkeep,
    input  logic                         s_axis_tvalid,
    output logic                         s_axis_tready,
    input  logic                         s_axis_tlast,
    input  logic [ID_WIDTH-1:0]          s_axis_tid,
    input  logic [DEST_WIDTH-1:0]        s_axis_tdest,
    input  logic [USER_WIDTH-1:0]        s_axis_tuser,
    output logic [DATA_WIDTH-1:0]        m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]        m_axis_tkeep,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic                         m_axis_tlast,
    output logic [ID_WIDTH-1:0]          m_axis_tid,
    output logic [DEST_WIDTH-1:0]        m_axis_tdest,
    output logic [USER_WIDTH-1:0]        m_axis_tuser,
    input  logic                         stat_clear,
    output logic [S_COUNT*CNT_WIDTH-1:0] stat_frames,
    output logic [S_COUNT*CNT_WIDTH-1:0] stat_trunc
);

    localparam int LEN_WIDTH     = $clog2(MAX_LEN + 1);
    localparam int PAYLOAD_WIDTH = DATA_WIDTH + KEEP_WIDTH + 1 + ID_WIDTH + DEST_WIDTH + USER_WIDTH;

    mon_state_t             state;
    logic [LEN_WIDTH-1:0]   len;
    logic                   accept;
    logic                   at_max;
    logic                   trunc;
    logic                   fwd_valid;
    logic                   fwd_last;
    logic [USER_WIDTH-1:0]  fwd_user;
    logic [KEEP_WIDTH-1:0]  fwd_keep;
    logic [PAYLOAD_WIDTH-1:0] fwd_payload;
    logic [PAYLOAD_WIDTH-1:0] out_payload;

    assign accept    = s_axis_tvalid && s_axis_tready;
    assign at_max    = (len == LEN_WIDTH'(MAX_LEN - 1));
    assign trunc     = (state == PASS) && at_max && !s_axis_tlast;
    assign fwd_valid = s_axis_tvalid && (state == PASS);
    assign fwd_last  = s_axis_tlast || trunc;
    assign fwd_user  = s_axis_tuser | (USER_WIDTH'(trunc) << USER_ERR_BIT);
    // Without tkeep the stream is treated as always fully populated.
    assign fwd_keep  = s_axis_tkeep | {KEEP_WIDTH{!KEEP_ENABLE}};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= PASS;
            len   <= '0;
        end else if (accept) begin
            case (state)
                PASS: begin
                    if (fwd_last) begin
                        len <= '0;
                        if (trunc) begin
                            state <= DROP;
                        end
                    end else begin
                        len <= len + LEN_WIDTH'(1);
                    end
                end
                DROP: begin
                    if (s_axis_tlast) begin
                        state <= PASS;
                    end
                end
                default: state <= PASS;
            endcase
        end
    end

    assign fwd_payload = {s_axis_tdata, fwd_keep, fwd_last, s_axis_tid, s_axis_tdest, fwd_user};

    axis_skid_reg #(
        .WIDTH(PAYLOAD_WIDTH)
    ) u_skid (
        .clk    (clk),
        .rst    (rst),
        .s_data (fwd_payload),
        .s_valid(fwd_valid),
        .s_ready(s_axis_tready),
        .m_data (out_payload),
        .m_valid(m_axis_tvalid),
        .m_ready(m_axis_tready)
    );

    assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tid, m_axis_tdest, m_axis_tuser} = out_payload;

`ifdef AXIS_FRAME_MONITOR_STATS_EN
    logic [CNT_WIDTH-1:0] frames_cnt [S_COUNT];
    logic [CNT_WIDTH-1:0] trunc_cnt  [S_COUNT];
    logic                 frame_end;
    logic                 trunc_end;

    assign frame_end = accept && (state == PASS) && fwd_last;
    assign trunc_end = accept && trunc;

    // Clear wins over a same-cycle increment; tids outside 0..S_COUNT-1 match no counter.
    always_ff @(posedge clk) begin
        if (rst || stat_clear) begin
            for (int i = 0; i < S_COUNT; i++) begin
                frames_cnt[i] <= '0;
                trunc_cnt[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < S_COUNT; i++) begin
                if (frame_end && (32'(s_axis_tid) == i)) begin
                    frames_cnt[i] <= CNT_WIDTH'(sat_inc(64'(frames_cnt[i]), CNT_WIDTH));
                end
                if (trunc_end && (32'(s_axis_tid) == i)) begin
                    trunc_cnt[i] <= CNT_WIDTH'(sat_inc(64'(trunc_cnt[i]), CNT_WIDTH));
                end
            end
        end
    end

    for (genvar g = 0; g < S_COUNT; g++) begin : g_stat_out
        assign stat_frames[g*CNT_WIDTH +: CNT_WIDTH] = frames_cnt[g];
        assign stat_trunc[g*CNT_WIDTH +: CNT_WIDTH]  = trunc_cnt[g];
    end
`else
    logic unused_stat_clear;

    assign unused_stat_clear = stat_clear;
    assign stat_frames       = '0;
    assign stat_trunc        = '0;
`endif

endmodule
